seq_ctrl: RTL and testbench

Parametrised run-control and fetch sequencer for the processor core. It is the successor to the bare program counter plus `done` compare.
- Owns the program counter and the req/done handshake.
- Resolves absolute jumps and conditional relative branches.
- Registers the ALU flags used by branch conditions.
- Drives the instruction ROM address and a `run` qualifier that gates RegWrite/MemWrite in the datapath.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_next_pc.sv | 44 ++++
 rtl/seq_ctrl.sv | 130 +++++++++++++
 tb/tb_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the run-control / fetch sequencer.
package seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_NZ     = 2'b10;
  localparam logic [1:0] COND_P      = 2'b11;

  localparam int SEQ_D          = 12;
  localparam int SEQ_OFS_W      = 8;
  localparam int SEQ_START_ADDR = 0;
  localparam int SEQ_END_ADDR   = 128;
endpackage

// File: rtl/seq_next_pc.sv
// Next-PC select: absolute jump over taken relative branch over sequential +1.
module seq_next_pc
  import seq_pkg::*;
#(
  parameter int D     = SEQ_D,
  parameter int OFS_W = SEQ_OFS_W
) (
  input  logic [D-1:0]     i_pc,
  input  logic             i_absjump_en,
  input  logic [D-1:0]     i_target,
  input  logic             i_reljump_en,
  input  logic [1:0]       i_rel_cond,
  input  logic [OFS_W-1:0] i_rel_offset,
  input  logic             i_zeroQ,
  input  logic             i_pariQ,
  output logic [D-1:0]     o_next_pc
);
  logic signed [OFS_W-1:0] w_ofs;
  logic        [D-1:0]     w_ofs_ext;
  logic                    w_cond;

  assign w_ofs     = i_rel_offset;
  // Sign-extending cast; the add below wraps modulo 2^D naturally.
  assign w_ofs_ext = D'(w_ofs);

  always_comb begin
    w_cond = 1'b0;
    case (i_rel_cond)
      COND_ALWAYS: w_cond = 1'b1;
      COND_Z:      w_cond = i_zeroQ;
      COND_NZ:     w_cond = ~i_zeroQ;
      COND_P:      w_cond = i_pariQ;
      default:     w_cond = 1'b0;
    endcase
  end

  always_comb begin
    o_next_pc = i_pc + D'(1);
    if (i_absjump_en)
      o_next_pc = i_target;
    else if (i_reljump_en && w_cond)
      o_next_pc = i_pc + w_ofs_ext;
  end
endmodule

// File: rtl/seq_ctrl.sv
// Run-control and fetch sequencer: PC, req/done handshake, branch flags.
// Optional cycle counter output enabled by SEQ_CTRL_CYCLE_CNT_EN.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int D          = SEQ_D,
  parameter int OFS_W      = SEQ_OFS_W,
  parameter int START_ADDR = SEQ_START_ADDR,
  parameter int END_ADDR   = SEQ_END_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic             halt,
  input  logic             absjump_en,
  input  logic [D-1:0]     target,
  input  logic             reljump_en,
  input  logic [1:0]       rel_cond,
  input  logic [OFS_W-1:0] rel_offset,
  input  logic             flag_en,
  input  logic             zero,
  input  logic             pari,
  input  logic             sc_o,
  input  logic             sc_clr,
  output logic [D-1:0]     prog_ctr,
  output logic             run,
  output logic             done,
  output logic             zeroQ,
  output logic             pariQ,
  output logic             sc_in
`ifdef SEQ_CTRL_CYCLE_CNT_EN
  ,
  output logic [15:0]      cycle_cnt
`endif
);
  localparam logic [D-1:0] L_START = D'(START_ADDR);
  localparam logic [D-1:0] L_END   = D'(END_ADDR);

  state_t       r_state, w_state_nxt;
  logic [D-1:0] r_pc, w_pc_nxt, w_pc_sel;
  logic         r_zq, r_pq, r_sc;
  logic         w_zq_nxt, w_pq_nxt, w_sc_nxt;

  seq_next_pc #(.D(D), .OFS_W(OFS_W)) u_next_pc (
    .i_pc         (r_pc),
    .i_absjump_en (absjump_en),
    .i_target     (target),
    .i_reljump_en (reljump_en),
    .i_rel_cond   (rel_cond),
    .i_rel_offset (rel_offset),
    .i_zeroQ      (r_zq),
    .i_pariQ      (r_pq),
    .o_next_pc    (w_pc_sel)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_zq_nxt    = r_zq;
    w_pq_nxt    = r_pq;
    w_sc_nxt    = r_sc;
    case (r_state)
      IDLE: begin
        w_pc_nxt = L_START;
        if (req) w_state_nxt = RUN;
      end
      RUN: begin
        // Stall freezes everything; branches see flags from before this cycle.
        if (!stall) begin
          if (r_pc == L_END || halt) w_state_nxt = DONE;
          else                       w_pc_nxt    = w_pc_sel;
          if (flag_en) begin
            w_zq_nxt = zero;
            w_pq_nxt = pari;
          end
          if (sc_clr)       w_sc_nxt = 1'b0;
          else if (flag_en) w_sc_nxt = sc_o;
        end
      end
      DONE: begin
        if (!req) begin
          w_state_nxt = IDLE;
          w_pc_nxt    = L_START;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = L_START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= L_START;
      r_zq    <= 1'b0;
      r_pq    <= 1'b0;
      r_sc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_zq    <= w_zq_nxt;
      r_pq    <= w_pq_nxt;
      r_sc    <= w_sc_nxt;
    end
  end

`ifdef SEQ_CTRL_CYCLE_CNT_EN
  logic [15:0] r_cnt;
  // Counts stalled RUN cycles too; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= 16'd0;
    else if (r_state == IDLE && req)
      r_cnt <= 16'd0;
    else if (r_state == RUN && r_cnt != 16'hFFFF)
      r_cnt <= r_cnt + 16'd1;
  end
  assign cycle_cnt = r_cnt;
`endif

  assign prog_ctr = r_pc;
  assign run      = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign zeroQ    = r_zq;
  assign pariQ    = r_pq;
  assign sc_in    = r_sc;
endmodule

// File: tb/tb_seq_ctrl.sv
// Directed plus randomized bench for seq_ctrl against a behavioural model.
module tb_seq_ctrl;
  localparam int D = 12;
  localparam int OFS_W = 8;
  localparam int START = 0;
  localparam int ENDA = 128;
  localparam int MASK = (1 << D) - 1;

  logic clk = 1'b0;
  logic reset, req, stall, halt, absjump_en, reljump_en, flag_en;
  logic zero, pari, sc_o, sc_clr;
  logic [D-1:0] target;
  logic [1:0] rel_cond;
  logic [OFS_W-1:0] rel_offset;
  logic [D-1:0] prog_ctr;
  logic run, done, zeroQ, pariQ, sc_in;
`ifdef SEQ_CTRL_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  seq_ctrl #(.D(D), .OFS_W(OFS_W), .START_ADDR(START), .END_ADDR(ENDA)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .halt(halt),
    .absjump_en(absjump_en), .target(target), .reljump_en(reljump_en),
    .rel_cond(rel_cond), .rel_offset(rel_offset), .flag_en(flag_en),
    .zero(zero), .pari(pari), .sc_o(sc_o), .sc_clr(sc_clr),
    .prog_ctr(prog_ctr), .run(run), .done(done), .zeroQ(zeroQ),
    .pariQ(pariQ), .sc_in(sc_in)
`ifdef SEQ_CTRL_CYCLE_CNT_EN
    , .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: mode 0 = idle, 1 = running, 2 = finished
  int m_mode, m_pc, m_z, m_p, m_sc, m_cnt;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    reset = 0; stall = 0; halt = 0; absjump_en = 0; reljump_en = 0;
    flag_en = 0; zero = 0; pari = 0; sc_o = 0; sc_clr = 0;
    target = '0; rel_cond = 2'b00; rel_offset = '0;
  endtask

  function automatic bit cond_true(input logic [1:0] c);
    case (c)
      2'b00: return 1'b1;
      2'b01: return m_z != 0;
      2'b10: return m_z == 0;
      default: return m_p != 0;
    endcase
  endfunction

  task automatic model_edge();
    int ofs;
    if (reset) begin
      m_mode = 0; m_pc = START; m_z = 0; m_p = 0; m_sc = 0; m_cnt = 0;
      return;
    end
    if (m_mode == 0) begin
      m_pc = START;
      if (req) begin m_mode = 1; m_cnt = 0; end
    end else if (m_mode == 1) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (!stall) begin
        ofs = int'($signed(rel_offset));
        if (m_pc == ENDA || halt) m_mode = 2;
        else if (absjump_en) m_pc = int'(target);
        else if (reljump_en && cond_true(rel_cond)) m_pc = (m_pc + ofs) & MASK;
        else m_pc = (m_pc + 1) & MASK;
        if (flag_en) begin m_z = zero; m_p = pari; end
        if (sc_clr) m_sc = 0;
        else if (flag_en) m_sc = sc_o;
      end
    end else begin
      if (!req) begin m_mode = 0; m_pc = START; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("prog_ctr", prog_ctr, m_pc);
    chk("run", run, m_mode == 1);
    chk("done", done, m_mode == 2);
    chk("zeroQ", zeroQ, m_z);
    chk("pariQ", pariQ, m_p);
    chk("sc_in", sc_in, m_sc);
`ifdef SEQ_CTRL_CYCLE_CNT_EN
    chk("cycle_cnt", cycle_cnt, m_cnt);
`endif
  endtask

  task automatic goto_pc(input int pc);
    absjump_en = 1; target = D'(pc);
    step();
    absjump_en = 0;
  endtask

  task automatic run_to_done(input int budget);
    int k = 0;
    while (m_mode != 2 && k < budget) begin step(); k++; end
    if (m_mode != 2) chk("done_timeout", 0, 1);
  endtask

  initial begin
    clr_in(); req = 0; reset = 1;
    m_mode = 0; m_pc = START; m_z = 0; m_p = 0; m_sc = 0; m_cnt = 0;
    step(); step();
    reset = 0;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_run", run, 0);

    // Straight-line program 0..128
    req = 1; step(); req = 0;
    chk("start_run", run, 1);
    chk("start_pc", prog_ctr, 0);
    req = 1;
    run_to_done(200);
    chk("end_pc", prog_ctr, ENDA);
    chk("end_done", done, 1);
    step();
    chk("hold_pc", prog_ctr, ENDA);
    req = 0; step();
    chk("back_idle_pc", prog_ctr, 0);
    chk("back_idle_done", done, 0);

    // Jump priority and relative branches
    req = 1; step(); req = 0;
    goto_pc(10);
    absjump_en = 1; target = 40; reljump_en = 1; rel_cond = 2'b00; rel_offset = 8'd5;
    step(); clr_in();
    chk("abs_over_rel", prog_ctr, 40);
    goto_pc(10);
    reljump_en = 1; rel_cond = 2'b00; rel_offset = 8'd5; step(); clr_in();
    chk("rel_fwd", prog_ctr, 15);
    goto_pc(3);
    reljump_en = 1; rel_cond = 2'b00; rel_offset = 8'hFB; step(); clr_in();
    chk("rel_wrap", prog_ctr, 12'hFFE);

    // Flag-conditioned branches
    goto_pc(20);
    flag_en = 1; zero = 1; step(); clr_in();
    chk("flag_z", zeroQ, 1);
    reljump_en = 1; rel_cond = 2'b01; rel_offset = 8'd4; step(); clr_in();
    chk("br_z_taken", prog_ctr, 25);
    goto_pc(21);
    reljump_en = 1; rel_cond = 2'b10; rel_offset = 8'd4; step(); clr_in();
    chk("br_nz_not", prog_ctr, 22);
    flag_en = 1; zero = 0; reljump_en = 1; rel_cond = 2'b01; rel_offset = 8'd4;
    step(); clr_in();
    chk("br_old_flag", prog_ctr, 26);
    chk("flag_z_new", zeroQ, 0);

    // Stall with pending halt
    goto_pc(50);
    stall = 1; halt = 1; flag_en = 1; zero = 1; pari = 1; sc_o = 1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_pc", prog_ctr, 50);
    chk("stall_run", run, 1);
    chk("stall_flags", {zeroQ, pariQ, sc_in}, 0);
    clr_in(); halt = 1; step(); clr_in();
    chk("halt_done", done, 1);
    chk("halt_pc", prog_ctr, 50);

    // Reset mid-run
    req = 0; step();
    req = 1; step(); req = 0;
    goto_pc(77);
    flag_en = 1; zero = 1; pari = 1; sc_o = 1; step(); clr_in();
    chk("pre_rst_sc", sc_in, 1);
    reset = 1; step(); reset = 0;
    chk("mid_rst_pc", prog_ctr, 0);
    chk("mid_rst_run", run, 0);
    chk("mid_rst_flags", {zeroQ, pariQ, sc_in}, 0);
    req = 1; step(); req = 0;
    flag_en = 1; sc_o = 1; step(); clr_in();
    chk("sc_set", sc_in, 1);
    flag_en = 1; sc_o = 1; sc_clr = 1; step(); clr_in();
    chk("sc_clr_wins", sc_in, 0);

    // Full run with two stalls
    reset = 1; step(); reset = 0;
    req = 1; step();
    for (int i = 0; i < 5; i++) step();
    stall = 1; step(); step(); stall = 0;
    run_to_done(200);
    step();
`ifdef SEQ_CTRL_CYCLE_CNT_EN
    chk("cnt_total", cycle_cnt, 131);
`endif
    chk("cnt_run_done", done, 1);
    req = 0; step(); req = 1; step();
`ifdef SEQ_CTRL_CYCLE_CNT_EN
    chk("cnt_clear", cycle_cnt, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      req        = ($urandom_range(0, 9) != 0);
      stall      = ($urandom_range(0, 7) == 0);
      halt       = ($urandom_range(0, 63) == 0);
      absjump_en = ($urandom_range(0, 15) == 0);
      target     = ($urandom_range(0, 3) == 0) ? D'($urandom) : D'($urandom_range(100, 130));
      reljump_en = ($urandom_range(0, 3) == 0);
      rel_cond   = 2'($urandom);
      rel_offset = OFS_W'($urandom);
      flag_en    = ($urandom_range(0, 2) == 0);
      zero       = 1'($urandom);
      pari       = 1'($urandom);
      sc_o       = 1'($urandom);
      sc_clr     = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
